// File: rtl/kmi_rx_fifo.sv
// rtl/kmi_rx_fifo.sv - KMI receive FIFO with APB register access and level interrupt
//
// Purpose:
//   Buffers bytes completed by the KMI deserialiser (with their parity-error
//   flag) in a DEPTH-entry FIFO. The processor drains it over APB. A level
//   interrupt signals that unread data or an overrun is pending.
//
// Ports:
//   pclk      - APB clock, sole clock of the block
//   kmirst    - asynchronous active-high reset
//   rx_valid  - one-cycle pulse: rx_data/rx_perr hold a completed byte
//   rx_data   - received byte
//   rx_perr   - parity error flag for rx_data
//   psel      - APB select
//   penable   - APB enable
//   pwrite    - APB direction, 1 = write
//   paddr     - register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   pwdata    - APB write data
//   prdata    - APB read data (combinational while psel=1, else 8'h00)
//   pready    - APB ready, registered, one wait state
//   kmiintr   - registered level interrupt: rxie & (~empty | overrun)
//
// Build option:
//   KMI_RX_PERR_DROP_EN - when defined, bytes arriving with rx_perr=1 are
//   discarded instead of stored, and STATUS[2] always reads 0.

module kmi_rx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       pclk,
    input  logic       kmirst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_perr,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [1:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       kmiintr
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    // Storage: {perr, data} per entry
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic rxie;
    logic overrun;
    logic access_done;

    logic empty;
    logic full;
    logic xfer;
    logic pop;
    logic push;
    logic rx_keep;
    logic drop;
    logic ctrl_wr;
    logic flush;
    logic ovr_clr;
    logic [8:0] head;
    logic       head_perr;

    // Bits of pwdata that have no register field behind them
    logic unused_pwdata;
    assign unused_pwdata = &{1'b0, pwdata[7:3]};

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);
    assign head  = mem[rptr];

`ifdef KMI_RX_PERR_DROP_EN
    assign rx_keep   = rx_valid & ~rx_perr;
    assign head_perr = 1'b0;
`else
    assign rx_keep   = rx_valid;
    assign head_perr = ~empty & head[8];
`endif

    // A transfer completes exactly once: the first edge where pready is high,
    // guarded by access_done until penable drops.
    assign xfer    = psel & penable & pready & ~access_done;
    assign pop     = xfer & ~pwrite & (paddr == ADDR_DATA) & ~empty;
    assign ctrl_wr = xfer & pwrite & (paddr == ADDR_CTRL);
    assign flush   = ctrl_wr & pwdata[1];
    assign ovr_clr = ctrl_wr & pwdata[2];

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push = rx_keep & (~full | pop);
    assign drop = rx_keep & full & ~pop;

    // APB handshake: pready follows the access phase by one cycle
    always_ff @(posedge pclk or posedge kmirst) begin
        if (kmirst) begin
            pready      <= 1'b0;
            access_done <= 1'b0;
        end else begin
            pready <= psel & penable;
            if (!penable) begin
                access_done <= 1'b0;
            end else if (xfer) begin
                access_done <= 1'b1;
            end
        end
    end

    // Pointers and count; flush overrides any push or pop on the same edge
    always_ff @(posedge pclk or posedge kmirst) begin
        if (kmirst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by count
    always_ff @(posedge pclk) begin
        if (push && !flush) begin
            mem[wptr] <= {rx_perr, rx_data};
        end
    end

    // Control and sticky status; a new overrun beats a clear on the same edge
    always_ff @(posedge pclk or posedge kmirst) begin
        if (kmirst) begin
            rxie    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rxie <= pwdata[0];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge kmirst) begin
        if (kmirst) begin
            kmiintr <= 1'b0;
        end else begin
            kmiintr <= rxie & (~empty | overrun);
        end
    end

    always_comb begin
        prdata = 8'h00;
        if (psel) begin
            case (paddr)
                ADDR_DATA:   prdata = empty ? 8'h00 : head[7:0];
                ADDR_STATUS: prdata = {4'(count), overrun, head_perr, full, empty};
                ADDR_CTRL:   prdata = {7'b0, rxie};
                default:     prdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_kmi_rx_fifo.sv
// tb/tb_kmi_rx_fifo.sv - scoreboard testbench for kmi_rx_fifo

module tb_kmi_rx_fifo;

    localparam int DEPTH = 8;

    logic       pclk = 1'b0;
    logic       kmirst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_perr = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [1:0] paddr = 2'd0;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       kmiintr;

    int total = 0;
    int bad = 0;

    // Scoreboard: {perr, data} in arrival order, plus sticky overrun
    logic [8:0] sb[$];
    logic       m_ovr = 1'b0;

    kmi_rx_fifo #(.DEPTH(DEPTH)) dut (
        .pclk(pclk), .kmirst(kmirst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .kmiintr(kmiintr)
    );

    always #5 pclk = ~pclk;

    function automatic void model_push(input logic [7:0] d, input logic p);
`ifdef KMI_RX_PERR_DROP_EN
        if (p) return;
`endif
        if (sb.size() == DEPTH) m_ovr = 1'b1;
        else sb.push_back({p, d});
    endfunction

    function automatic logic [7:0] status_exp();
        logic [3:0] c;
        logic e, f, pe;
        c  = 4'(sb.size());
        e  = (sb.size() == 0);
        f  = (sb.size() == DEPTH);
        pe = 1'b0;
`ifndef KMI_RX_PERR_DROP_EN
        if (!e) pe = sb[0][8];
`endif
        return {c, m_ovr, pe, f, e};
    endfunction

    task automatic rx_push(input logic [7:0] d, input logic p);
        @(negedge pclk);
        rx_valid = 1'b1; rx_data = d; rx_perr = p;
        model_push(d, p);
        @(negedge pclk);
        rx_valid = 1'b0;
    endtask

    // Full APB transfer; optionally pulses rx_valid on the completing edge
    task automatic apb_xfer(input logic wr, input logic [1:0] addr, input logic [7:0] wd,
                            input logic pe, input logic [7:0] pd, input logic pp,
                            output logic [7:0] rd);
        int n;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        @(negedge pclk);
        while (!pready && n < 10) begin
            @(negedge pclk);
            n++;
        end
        total++;
        if (pready !== 1'b1) begin
            bad++;
            $display("FAIL pready_timeout: pready=%b required=1", pready);
        end
        rd = prdata;
        if (pe) begin
            rx_valid = 1'b1; rx_data = pd; rx_perr = pp;
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] addr, output logic [7:0] rd);
        apb_xfer(1'b0, addr, 8'h00, 1'b0, 8'h00, 1'b0, rd);
    endtask

    task automatic apb_write(input logic [1:0] addr, input logic [7:0] wd);
        logic [7:0] dummy;
        apb_xfer(1'b1, addr, wd, 1'b0, 8'h00, 1'b0, dummy);
    endtask

    task automatic check_status(input string name);
        logic [7:0] rd, ex;
        ex = status_exp();
        apb_read(2'd1, rd);
        total++;
        if (rd !== ex) begin
            bad++;
            $display("FAIL %s: status=%h required=%h", name, rd, ex);
        end
    endtask

    task automatic check_pop(input string name);
        logic [7:0] rd, ex;
        ex = (sb.size() == 0) ? 8'h00 : sb.pop_front()[7:0];
        apb_read(2'd0, rd);
        total++;
        if (rd !== ex) begin
            bad++;
            $display("FAIL %s: data=%h required=%h", name, rd, ex);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        repeat (3) @(negedge pclk);
        kmirst = 1'b0;
        @(negedge pclk);
        total++;
        if (pready !== 1'b0 || kmiintr !== 1'b0 || prdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: pready=%b kmiintr=%b prdata=%h required=0 0 00",
                     pready, kmiintr, prdata);
        end
        check_status("reset_status");
        apb_read(2'd2, rd);
        total++;
        if (rd !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: ctrl=%h required=00", rd);
        end
    endtask

    task automatic test_basic();
        rx_push(8'hCD, 1'b0);
        check_status("basic_status_one");
        check_pop("basic_data");
        check_status("basic_status_empty");
    endtask

    task automatic test_interrupt();
        logic [7:0] rd;
        apb_write(2'd2, 8'h01);
        apb_read(2'd2, rd);
        total++;
        if (rd !== 8'h01) begin
            bad++;
            $display("FAIL ctrl_rxie: ctrl=%h required=01", rd);
        end
        rx_push(8'h6C, 1'b0);
        total++;
        if (kmiintr !== 1'b0) begin
            bad++;
            $display("FAIL intr_lag: kmiintr=%b required=0", kmiintr);
        end
        @(negedge pclk);
        total++;
        if (kmiintr !== 1'b1) begin
            bad++;
            $display("FAIL intr_rise: kmiintr=%b required=1", kmiintr);
        end
        check_pop("intr_data");
        total++;
        if (kmiintr !== 1'b1) begin
            bad++;
            $display("FAIL intr_hold: kmiintr=%b required=1", kmiintr);
        end
        @(negedge pclk);
        total++;
        if (kmiintr !== 1'b0) begin
            bad++;
            $display("FAIL intr_fall: kmiintr=%b required=0", kmiintr);
        end
        apb_write(2'd2, 8'h00);
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 9; i++) rx_push(8'(i), 1'b0);
        check_status("ovr_status_full");
        for (int i = 0; i < DEPTH; i++) check_pop("ovr_drain");
        check_status("ovr_status_sticky");
        apb_write(2'd2, 8'h04);
        m_ovr = 1'b0;
        check_status("ovr_cleared");
    endtask

    task automatic test_hold();
        logic [7:0] cap, ex;
        logic got;
        rx_push(8'hA1, 1'b0);
        rx_push(8'hA2, 1'b0);
        rx_push(8'hA3, 1'b0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 2'd0;
        @(negedge pclk);
        penable = 1'b1;
        got = 1'b0;
        cap = 8'h00;
        for (int i = 0; i < 25; i++) begin
            @(negedge pclk);
            if (pready && !got) begin
                cap = prdata;
                got = 1'b1;
            end
        end
        psel = 1'b0; penable = 1'b0;
        ex = sb.pop_front()[7:0];
        total++;
        if (!got || cap !== ex) begin
            bad++;
            $display("FAIL hold_data: got=%b data=%h required=%h", got, cap, ex);
        end
        check_status("hold_count");
        check_pop("hold_drain");
        check_pop("hold_drain");
    endtask

    task automatic test_full_simul();
        logic [7:0] rd, ex;
        for (int i = 0; i < DEPTH; i++) rx_push(8'h10 + 8'(i), 1'b0);
        apb_xfer(1'b0, 2'd0, 8'h00, 1'b1, 8'h55, 1'b0, rd);
        ex = sb.pop_front()[7:0];
        sb.push_back({1'b0, 8'h55});
        total++;
        if (rd !== ex) begin
            bad++;
            $display("FAIL simul_data: data=%h required=%h", rd, ex);
        end
        check_status("simul_status");
        for (int i = 0; i < DEPTH; i++) check_pop("simul_drain");
    endtask

    task automatic test_perr();
        rx_push(8'hAA, 1'b1);
        check_status("perr_status");
        check_pop("perr_data");
        check_status("perr_empty");
    endtask

    task automatic test_flush();
        logic [7:0] rd;
        rx_push(8'h31, 1'b0);
        rx_push(8'h32, 1'b0);
        apb_write(2'd2, 8'h02);
        sb.delete();
        check_status("flush_status");
        rx_push(8'h41, 1'b0);
        apb_xfer(1'b1, 2'd2, 8'h02, 1'b1, 8'h77, 1'b0, rd);
        sb.delete();
        check_status("flush_push_status");
        apb_write(2'd0, 8'h99);
        check_status("data_write_ignored");
    endtask

    task automatic test_reset_mid();
        int n;
        rx_push(8'h3C, 1'b0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 2'd0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        kmirst = 1'b1;
        #1;
        sb.delete();
        m_ovr = 1'b0;
        total++;
        if (pready !== 1'b0 || prdata !== 8'h00) begin
            bad++;
            $display("FAIL midrst_clear: pready=%b prdata=%h required=0 00", pready, prdata);
        end
        @(negedge pclk);
        kmirst = 1'b0;
        n = 0;
        @(negedge pclk);
        while (!pready && n < 10) begin
            @(negedge pclk);
            n++;
        end
        total++;
        if (pready !== 1'b1 || prdata !== 8'h00 || n != 0) begin
            bad++;
            $display("FAIL midrst_resume: pready=%b prdata=%h waits=%0d required=1 00 0",
                     pready, prdata, n);
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        check_status("midrst_status");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interrupt();
        test_overrun();
        test_hold();
        test_full_simul();
        test_perr();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
